sensor_frame_serializer: RTL and testbench

Successor to the sensor messaging controller. Snapshots a parametrised vector of sensor samples and emits it to the SPI transmit path as a framed sequence of WORD_WIDTH words: header, payload, optional checksum. It adds a real frame state machine, input capture, a frame sequence number and tx-ready backpressure. It sits between the sensor aggregation logic and the SPI slave transmitter.

---
 rtl/sensor_frame_serializer.sv | 163 ++++++++++++++++
 tb/tb_sensor_frame_serializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_serializer.sv
// Snapshots 2*SENSORS samples and streams them as header/payload[/checksum] words to the SPI TX.
// Define SERIALIZER_CHECKSUM_EN to append a modulo-2^WORD_WIDTH payload checksum word.
module sensor_frame_serializer #(
  parameter int unsigned SENSORS    = 1,
  parameter int unsigned BITWIDTH   = 32,
  parameter int unsigned WORD_WIDTH = 16,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2*SENSORS*BITWIDTH-1:0]   data,
  input  logic                            data_ready,
  output logic                            ack,
  output logic [WORD_WIDTH-1:0]           spi_out,
  output logic                            write,
  input  logic                            spi_tx_ready,
  output logic                            busy,
  output logic [7:0]                      seq
);

  localparam int unsigned CapW   = 2 * SENSORS * BITWIDTH;
  localparam int unsigned NWords = (CapW + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned PadW   = NWords * WORD_WIDTH;
  localparam int unsigned IdxW   = (NWords > 1) ? $clog2(NWords) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWords - 1);

`ifdef SERIALIZER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHeader, StPayload, StCheck, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StHeader, StPayload, StDone} state_e;
`endif

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CapW-1:0]       cap_q, cap_d;
  logic [WORD_WIDTH-1:0] spi_q, spi_d;
  logic                  write_q, write_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic [7:0]            seq_q, seq_d;
`ifdef SERIALIZER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] csum_q, csum_d;
`endif

  logic [PadW-1:0]       cap_pad;
  logic [WORD_WIDTH-1:0] cur_word;
  logic [WORD_WIDTH-1:0] hdr_word;

  // Final word is zero-padded in its MSBs.
  assign cap_pad  = PadW'(cap_q);
  assign cur_word = cap_pad[idx_q*WORD_WIDTH +: WORD_WIDTH];

  always_comb begin
    hdr_word                      = '0;
    hdr_word[WORD_WIDTH-1 -: 8]   = MAGIC;
    hdr_word[7:0]                 = seq_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    spi_d   = spi_q;
    write_d = 1'b0;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    seq_d   = seq_q;
`ifdef SERIALIZER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (data_ready) begin
          cap_d   = data;
          busy_d  = 1'b1;
          idx_d   = '0;
`ifdef SERIALIZER_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = StHeader;
        end
      end
      StHeader: begin
        if (spi_tx_ready) begin
          spi_d   = hdr_word;
          write_d = 1'b1;
          idx_d   = '0;
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (spi_tx_ready) begin
          spi_d   = cur_word;
          write_d = 1'b1;
`ifdef SERIALIZER_CHECKSUM_EN
          csum_d  = csum_q + cur_word;
`endif
          if (idx_q == LastIdx) begin
`ifdef SERIALIZER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      StCheck: begin
        if (spi_tx_ready) begin
          spi_d   = csum_q;
          write_d = 1'b1;
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        seq_d   = seq_q + 8'd1;
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cap_q   <= '0;
      spi_q   <= '0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      seq_q   <= '0;
`ifdef SERIALIZER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      spi_q   <= spi_d;
      write_q <= write_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      seq_q   <= seq_d;
`ifdef SERIALIZER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign ack     = ack_q;
  assign spi_out = spi_q;
  assign write   = write_q;
  assign busy    = busy_q;
  assign seq     = seq_q;

endmodule

// File: tb/tb_sensor_frame_serializer.sv
// Directed, table-driven bench for sensor_frame_serializer (default and 24-bit sample builds).
module tb_sensor_frame_serializer;

`ifdef SERIALIZER_CHECKSUM_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data;
  logic        data_ready;
  logic        ack;
  logic [15:0] spi_out;
  logic        write;
  logic        spi_tx_ready;
  logic        busy;
  logic [7:0]  seq;

  logic [47:0] data24;
  logic        dr24;
  logic        ack24;
  logic [15:0] spi24;
  logic        write24;
  logic        busy24;
  logic [7:0]  seq24;

  always #5 clk = ~clk;

  sensor_frame_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .data_ready   (data_ready),
    .ack          (ack),
    .spi_out      (spi_out),
    .write        (write),
    .spi_tx_ready (spi_tx_ready),
    .busy         (busy),
    .seq          (seq)
  );

  sensor_frame_serializer #(
    .SENSORS    (1),
    .BITWIDTH   (24),
    .WORD_WIDTH (16),
    .MAGIC      (8'hA5)
  ) dut24 (
    .clk          (clk),
    .rst          (rst),
    .data         (data24),
    .data_ready   (dr24),
    .ack          (ack24),
    .spi_out      (spi24),
    .write        (write24),
    .spi_tx_ready (1'b1),
    .busy         (busy24),
    .seq          (seq24)
  );

  typedef struct {
    logic [63:0]      data;
    int               stall_at;
    int               stall_len;
    bit               hold;
    bit               disturb;
    logic [5:0][15:0] exp;
    logic [7:0]       exp_seq;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] got_w [0:7];
  int          got_n;
  int          first_cyc;
  int          ack_cyc;
  vec_t        vecs [0:5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] d, input int sa, input int sl, input bit h,
                              input bit dis, input logic [15:0] hdr, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [15:0] w2,
                              input logic [15:0] w3, input logic [15:0] cs,
                              input logic [7:0] sq);
    vec_t v;
    v.data = d; v.stall_at = sa; v.stall_len = sl; v.hold = h; v.disturb = dis;
    v.exp[0] = hdr; v.exp[1] = w0; v.exp[2] = w1; v.exp[3] = w2; v.exp[4] = w3;
    v.exp[5] = cs; v.exp_seq = sq;
    return v;
  endfunction

  // Drives one frame and records every write; stalls ready after write number stall_at.
  task automatic run_frame(input logic [63:0] d, input int stall_at, input int stall_len,
                           input bit hold, input bit disturb);
    int stall_left;
    bit was_low;
    data = d; data_ready = 1'b1;
    got_n = 0; first_cyc = -1; ack_cyc = -1; stall_left = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      was_low = !spi_tx_ready;
      @(posedge clk); #1;
      if (!hold) data_ready = 1'b0;
      if (was_low) begin
        check("stall_write", write, 1'b0);
        if (got_n > 0 && got_n <= 8) check("stall_hold", spi_out, got_w[got_n-1]);
        stall_left--;
        if (stall_left <= 0) spi_tx_ready = 1'b1;
      end else if (write) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (got_n < 8) got_w[got_n] = spi_out;
        got_n++;
        if (got_n - 1 == stall_at) begin
          spi_tx_ready = 1'b0;
          stall_left = stall_len;
        end
        if (disturb && got_n == 1) begin
          data = ~d;
          data_ready = 1'b1;
        end
      end
      if (ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) check("ack_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nw;
    int  extra_w;
    logic [7:0] e_seq;

    vecs[0] = mk(64'h4444_3333_2222_1111, -1, 0, 1'b0, 1'b0, 16'hA501,
                 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA, 8'd1);
    vecs[1] = mk(64'h4444_3333_2222_1111, 2, 3, 1'b0, 1'b0, 16'hA502,
                 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA, 8'd2);
    vecs[2] = mk(64'h0001_0002_0003_0004, -1, 0, 1'b1, 1'b0, 16'hA503,
                 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h000A, 8'd3);
    vecs[3] = mk(64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 1'b1, 1'b0, 16'hA504,
                 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFC, 8'd4);
    vecs[4] = mk(64'h8000_0001_7FFF_0000, -1, 0, 1'b0, 1'b0, 16'hA505,
                 16'h0000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 8'd5);
    vecs[5] = mk(64'hDEAD_BEEF_CAFE_F00D, -1, 0, 1'b0, 1'b1, 16'hA506,
                 16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD, 16'h58A7, 8'd6);

    rst = 1'b1; data = '0; data_ready = 1'b0; spi_tx_ready = 1'b1;
    data24 = '0; dr24 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_write", write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_spi_out", spi_out, 16'h0000);
    check("rst_seq", seq, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].data, vecs[i].stall_at, vecs[i].stall_len, vecs[i].hold,
                vecs[i].disturb);
      check($sformatf("v%0d_count", i), got_n, 5 + Extra);
      for (int j = 0; j < 5 + Extra; j++)
        check($sformatf("v%0d_w%0d", i, j), got_w[j], vecs[i].exp[j]);
      check($sformatf("v%0d_first", i), first_cyc, 2);
      check($sformatf("v%0d_ackcyc", i), ack_cyc,
            2 + 5 + Extra + ((vecs[i].stall_at >= 0) ? vecs[i].stall_len : 0));
      check($sformatf("v%0d_seq", i), seq, vecs[i].exp_seq);
      check($sformatf("v%0d_busy_at_ack", i), busy, 1'b0);
      if (vecs[i].disturb) begin
        extra_w = 0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          if (write || busy) extra_w++;
        end
        check("no_recapture", extra_w, 0);
      end
    end

    // 24-bit samples: 48 payload bits in three words.
    data24 = 48'hABCD_EF12_3456; dr24 = 1'b1;
    nw = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      dr24 = 1'b0;
      if (write24) begin
        if (nw < 8) got_w[nw] = spi24;
        nw++;
      end
      if (ack24) break;
    end
    check("w24_count", nw, 4 + Extra);
    check("w24_hdr", got_w[0], 16'hA501);
    check("w24_p0", got_w[1], 16'h3456);
    check("w24_p1", got_w[2], 16'hEF12);
    check("w24_p2", got_w[3], 16'hABCD);
    if (Extra == 1) check("w24_csum", got_w[4], 16'hCF35);
    check("w24_seq", seq24, 8'd1);

    // Reset after the second payload word abandons the frame.
    data = 64'h4444_3333_2222_1111; data_ready = 1'b1;
    nw = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      data_ready = 1'b0;
      if (write) nw++;
      if (nw == 3) break;
    end
    check("rst_mid_reach", nw, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_write", write, 1'b0);
    check("rst_mid_ack", ack, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_seq", seq, 8'h00);
    check("rst_mid_spi", spi_out, 16'h0000);
    run_frame(64'h4444_3333_2222_1111, -1, 0, 1'b0, 1'b0);
    check("post_rst_hdr", got_w[0], 16'hA501);
    check("post_rst_seq", seq, 8'd1);

    // Back-to-back frames through the 255 -> 0 sequence wrap.
    e_seq = 8'd1;
    for (int f = 0; f < 255; f++) begin
      run_frame(64'h0, -1, 0, (f < 254), 1'b0);
      e_seq = e_seq + 8'd1;
      check($sformatf("wrap_hdr%0d", f), got_w[0], {8'hA5, e_seq});
    end
    check("wrap_seq", seq, 8'h00);
    check("wrap_last_hdr", got_w[0], 16'hA500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
